register_bank_mp: RTL and testbench
===================================

# register_bank_mp

Parametrised multi-port ARM register bank for the pipeline's decode/writeback boundary, successor to the fixed 4-read/2-write bank. Provides NRD combinational read ports and NWR synchronous write ports with defined write-port priority and same-cycle write-to-read bypass. It holds a dedicated PC register with load/auto-increment and PC-relative read offset, and a CPSR with per-flag masked update.

## Interface
- N, 32, data width in bits
- NREGS, 16, number of general registers (power of two, ≥ 2); AW = $clog2(NREGS)
- NRD, 4, number of read ports (≥ 1)
- NWR, 2, number of write ports (≥ 1)
- PC_IDX, 15, register index aliased to the PC
- PC_RD_OFS, 8, value added to PC when PC_IDX is read
- PC_STEP, 4, auto-increment amount
- RESET_PC, 0, PC value after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd_data  out  NRD*N  read data, port k at [k*N +: N]
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses, port j at [j*AW +: AW]
- wr_data  in  NWR*N  write data, port j at [j*N +: N]
- pc  out  N  current PC register
- pc_update  in  N  explicit PC load value
- pc_write  in  1  load PC from pc_update
- pc_inc  in  1  advance PC by PC_STEP
- cspr  out  N  current status register
- cspr_update  in  N  new status value
- cspr_write  in  1  update enable
- cspr_mask  in  4  per-flag enable for bits N-1..N-4 (N,Z,C,V)

## Operation
- Storage: NREGS × N general array, plus PC and CPSR registers. Array entry PC_IDX is unused; PC_IDX is served by the PC register.
- Reset (rst=1 at posedge): all array entries ← 0, pc ← RESET_PC, cspr ← 0. All writes, pc_write, pc_inc and cspr_write are ignored in that cycle. The PC read on rd_data is still RESET_PC+PC_RD_OFS; all other reads return 0 from the next cycle.
- Array write, address A ≠ PC_IDX: among ports with wr_en=1 and wr_addr=A, the highest port index wins. Different addresses on different ports all commit in the same cycle.
- PC next-state priority:
  1. pc_write → pc_update.
  2. Else highest-index wr_en port with wr_addr=PC_IDX → its wr_data.
  3. Else pc_inc → pc+PC_STEP, modulo 2^N (wraps silently).
  4. Else hold.
- CPSR: when cspr_write=1, each bit i in N-4..N-1 with cspr_mask[i-(N-4)]=1 takes cspr_update[i]. Bits N-5..0 take cspr_update only when cspr_mask=4'b1111; otherwise they hold.
- Read port k, address A ≠ PC_IDX:
  - If any wr_en port targets A this cycle, return the winning port's wr_data (bypass, same priority as the write).
  - Else return the array entry.
- Read port k, address PC_IDX: return pc+PC_RD_OFS (registered PC, no bypass, modulo 2^N).
- No read-port conflicts: all NRD ports are independent and may share addresses.

## Timing
- rd_data is combinational from rd_addr, wr_en, wr_addr, wr_data and state; zero latency.
- Writes, PC and CPSR become visible on the pc/cspr outputs and on array reads in the cycle after the capturing edge.
- pc and cspr are register outputs, with no combinational path from inputs.
- Reset asserted mid-operation overrides every pending update on that edge; the first post-reset edge behaves normally.

## Test plan
- Reset: drive writes with rst=1 → after the edge all reads of R0..R14 = 0, pc = RESET_PC, cspr = 0, R15 read = 8.
- Sequential fill: write R0..R14 with 10..24 on port 0, read on port 0 one cycle later → R_i = 10+i. The same values read back on all 4 ports with distinct addresses simultaneously.
- Write conflict and bypass: port0 writes R3=0xAAAA and port1 writes R3=0x5555 in the same cycle → same-cycle read of R3 = 0x5555, next-cycle read = 0x5555. Port0 writing R4=1 concurrently → R4 = 1.
- PC priority:
  - pc_write=1 (0x100), pc_inc=1 and port1 writing R15=0x200 → pc = 0x100.
  - Next cycle, only the R15 write → 0x200.
  - Then pc_inc → 0x204.
  - pc = 0xFFFFFFFC with pc_inc → 0x00000000.
- CPSR mask: cspr=0, cspr_update=0xFFFFFFFF, mask=4'b1010 → cspr = 0xA0000000. Then mask=4'b1111, update=0x000000D3 → cspr = 0x000000D3.
- Mid-operation reset: rst=1 together with pc_write, cspr_write and a write to R2 → pc = RESET_PC, cspr = 0, R2 = 0 on the next cycle.

Source files
------------

// File: rtl/register_bank_mp.sv
// Multi-port ARM register bank: NRD combinational reads, NWR prioritised writes,
// dedicated PC with load/increment and a CPSR with per-flag masked update.
module register_bank_mp #(
  parameter int N         = 32,
  parameter int NREGS     = 16,
  parameter int NRD       = 4,
  parameter int NWR       = 2,
  parameter int PC_IDX    = 15,
  parameter int PC_RD_OFS = 8,
  parameter int PC_STEP   = 4,
  parameter int RESET_PC  = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*N-1:0]  rd_data,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*N-1:0]  wr_data,
  output logic [N-1:0]      pc,
  input  logic [N-1:0]      pc_update,
  input  logic              pc_write,
  input  logic              pc_inc,
  output logic [N-1:0]      cspr,
  input  logic [N-1:0]      cspr_update,
  input  logic              cspr_write,
  input  logic [3:0]        cspr_mask
);

  localparam logic [AW-1:0] PC_A  = AW'(PC_IDX);
  localparam logic [N-1:0]  OFS   = N'(PC_RD_OFS);
  localparam logic [N-1:0]  STEP  = N'(PC_STEP);
  localparam logic [N-1:0]  PC_RV = N'(RESET_PC);

  logic [N-1:0] regs [NREGS];
  logic [N-1:0] pc_next;
  logic [N-1:0] cspr_next;

  // Later loop iterations override earlier ones: highest port index wins.
  always_comb begin
    pc_next = pc;
    if (pc_inc) pc_next = pc + STEP;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] == PC_A)
        pc_next = wr_data[j*N +: N];
    end
    if (pc_write) pc_next = pc_update;
  end

  always_comb begin
    cspr_next = cspr;
    if (cspr_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cspr_mask[i]) cspr_next[N-4+i] = cspr_update[N-4+i];
      end
      if (&cspr_mask) cspr_next[N-5:0] = cspr_update[N-5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pc   <= PC_RV;
      cspr <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != PC_A)
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*N +: N];
      end
      pc   <= pc_next;
      cspr <= cspr_next;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [N-1:0]  v;
    assign a = rd_addr[k*AW +: AW];
    always_comb begin
      v = regs[a];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a)
          v = wr_data[j*N +: N];
      end
      if (a == PC_A) v = pc + OFS;
    end
    assign rd_data[k*N +: N] = v;
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench for register_bank_mp: reset, fill, write priority/bypass,
// PC priority and wrap, CPSR masking, mid-operation reset.
module tb_register_bank_mp;

  logic        clk;
  logic        rst;
  logic [15:0] rd_addr;
  logic [127:0] rd_data;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] pc;
  logic [31:0] pc_update;
  logic        pc_write;
  logic        pc_inc;
  logic [31:0] cspr;
  logic [31:0] cspr_update;
  logic        cspr_write;
  logic [3:0]  cspr_mask;

  int errors = 0;
  int checks = 0;

  register_bank_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc(pc), .pc_update(pc_update),
    .pc_write(pc_write), .pc_inc(pc_inc),
    .cspr(cspr), .cspr_update(cspr_update),
    .cspr_write(cspr_write), .cspr_mask(cspr_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    pc_write = 1'b0;
    pc_inc = 1'b0;
    cspr_write = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [3:0] a);
    rd_addr[k*4 +: 4] = a;
  endtask

  task automatic wr(input int j, input logic [3:0] a, input logic [31:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*4 +: 4] = a;
    wr_data[j*32 +: 32] = d;
  endtask

  function automatic logic [31:0] rd(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    idle();
    wr(0, 4'd1, 32'h1111);
    wr(1, 4'd2, 32'h2222);
    pc_write = 1'b1; pc_update = 32'h40;
    cspr_write = 1'b1; cspr_update = '1; cspr_mask = 4'hF;
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
    end
    checks++;
    if (cspr !== 32'h0) begin
      errors++; $display("FAIL reset_cspr: got %h want %h", cspr, 32'h0);
    end
    for (int i = 0; i < 15; i++) begin
      set_rd(0, 4'(i));
      #1;
      v = rd(0);
      checks++;
      if (v !== 32'h0) begin
        errors++; $display("FAIL reset_r%0d: got %h want %h", i, v, 32'h0);
      end
    end
    set_rd(0, 4'd15);
    #1;
    checks++;
    if (rd(0) !== 32'h8) begin
      errors++; $display("FAIL reset_r15: got %h want %h", rd(0), 32'h8);
    end
  endtask

  task automatic test_fill();
    logic [31:0] v;
    for (int i = 0; i < 15; i++) begin
      idle();
      wr(0, 4'(i), 32'(10 + i));
      tick();
    end
    idle();
    for (int i = 0; i < 15; i++) begin
      set_rd(0, 4'(i));
      #1;
      v = rd(0);
      checks++;
      if (v !== 32'(10 + i)) begin
        errors++; $display("FAIL fill_r%0d: got %h want %h", i, v, 32'(10 + i));
      end
    end
    set_rd(0, 4'd0); set_rd(1, 4'd5);
    set_rd(2, 4'd9); set_rd(3, 4'd14);
    #1;
    checks++;
    if (rd_data !== {32'd24, 32'd19, 32'd15, 32'd10}) begin
      errors++;
      $display("FAIL fill_4port: got %h want %h", rd_data,
               {32'd24, 32'd19, 32'd15, 32'd10});
    end
  endtask

  task automatic test_conflict();
    idle();
    wr(0, 4'd3, 32'hAAAA);
    wr(1, 4'd3, 32'h5555);
    set_rd(0, 4'd3);
    set_rd(1, 4'd4);
    #1;
    checks++;
    if (rd(0) !== 32'h5555) begin
      errors++; $display("FAIL bypass_r3: got %h want %h", rd(0), 32'h5555);
    end
    checks++;
    if (rd(1) !== 32'd14) begin
      errors++; $display("FAIL nobypass_r4: got %h want %h", rd(1), 32'd14);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd(0) !== 32'h5555) begin
      errors++; $display("FAIL commit_r3: got %h want %h", rd(0), 32'h5555);
    end
    wr(0, 4'd4, 32'h1);
    wr(1, 4'd5, 32'h7);
    set_rd(2, 4'd4);
    #1;
    checks++;
    if (rd(2) !== 32'h1) begin
      errors++; $display("FAIL bypass_p0_r4: got %h want %h", rd(2), 32'h1);
    end
    tick();
    idle();
    set_rd(0, 4'd4);
    set_rd(1, 4'd5);
    #1;
    checks++;
    if (rd(0) !== 32'h1) begin
      errors++; $display("FAIL dual_r4: got %h want %h", rd(0), 32'h1);
    end
    checks++;
    if (rd(1) !== 32'h7) begin
      errors++; $display("FAIL dual_r5: got %h want %h", rd(1), 32'h7);
    end
  endtask

  task automatic test_pc();
    idle();
    pc_write = 1'b1; pc_update = 32'h100;
    pc_inc = 1'b1;
    wr(1, 4'd15, 32'h200);
    tick();
    idle();
    checks++;
    if (pc !== 32'h100) begin
      errors++; $display("FAIL pc_load_prio: got %h want %h", pc, 32'h100);
    end
    wr(1, 4'd15, 32'h200);
    set_rd(0, 4'd15);
    #1;
    checks++;
    if (rd(0) !== 32'h108) begin
      errors++; $display("FAIL pc_read_nobypass: got %h want %h", rd(0), 32'h108);
    end
    tick();
    idle();
    checks++;
    if (pc !== 32'h200) begin
      errors++; $display("FAIL pc_port_write: got %h want %h", pc, 32'h200);
    end
    pc_inc = 1'b1;
    tick();
    idle();
    checks++;
    if (pc !== 32'h204) begin
      errors++; $display("FAIL pc_inc: got %h want %h", pc, 32'h204);
    end
    pc_write = 1'b1; pc_update = 32'hFFFF_FFFC;
    tick();
    idle();
    #1;
    checks++;
    if (rd(0) !== 32'h4) begin
      errors++; $display("FAIL pc_read_wrap: got %h want %h", rd(0), 32'h4);
    end
    pc_inc = 1'b1;
    tick();
    idle();
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL pc_wrap: got %h want %h", pc, 32'h0);
    end
  endtask

  task automatic test_cspr();
    idle();
    cspr_write = 1'b1; cspr_update = 32'hFFFF_FFFF; cspr_mask = 4'b1010;
    tick();
    idle();
    checks++;
    if (cspr !== 32'hA000_0000) begin
      errors++; $display("FAIL cspr_mask1010: got %h want %h", cspr, 32'hA000_0000);
    end
    cspr_write = 1'b1; cspr_update = 32'h0000_00D3; cspr_mask = 4'b1111;
    tick();
    idle();
    checks++;
    if (cspr !== 32'h0000_00D3) begin
      errors++; $display("FAIL cspr_full: got %h want %h", cspr, 32'h0000_00D3);
    end
    cspr_update = 32'h1234_5678;
    tick();
    checks++;
    if (cspr !== 32'h0000_00D3) begin
      errors++; $display("FAIL cspr_hold: got %h want %h", cspr, 32'h0000_00D3);
    end
    cspr_write = 1'b1; cspr_update = 32'hFFFF_FFFF; cspr_mask = 4'b0100;
    tick();
    idle();
    checks++;
    if (cspr !== 32'h4000_00D3) begin
      errors++; $display("FAIL cspr_z_only: got %h want %h", cspr, 32'h4000_00D3);
    end
  endtask

  task automatic test_mid_reset();
    idle();
    wr(0, 4'd2, 32'h55);
    tick();
    idle();
    rst = 1'b1;
    pc_write = 1'b1; pc_update = 32'h300;
    cspr_write = 1'b1; cspr_update = 32'h1234; cspr_mask = 4'hF;
    wr(0, 4'd2, 32'h99);
    tick();
    rst = 1'b0;
    idle();
    set_rd(0, 4'd2);
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL midrst_pc: got %h want %h", pc, 32'h0);
    end
    checks++;
    if (cspr !== 32'h0) begin
      errors++; $display("FAIL midrst_cspr: got %h want %h", cspr, 32'h0);
    end
    checks++;
    if (rd(0) !== 32'h0) begin
      errors++; $display("FAIL midrst_r2: got %h want %h", rd(0), 32'h0);
    end
    pc_inc = 1'b1;
    tick();
    idle();
    checks++;
    if (pc !== 32'h4) begin
      errors++; $display("FAIL post_rst_inc: got %h want %h", pc, 32'h4);
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    pc_update = '0;
    pc_write = 1'b0;
    pc_inc = 1'b0;
    cspr_update = '0;
    cspr_write = 1'b0;
    cspr_mask = '0;
    test_reset();
    test_fill();
    test_conflict();
    test_pc();
    test_cspr();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
